// File: rtl/matriz_loader5x5_if.sv
// Bundle between the element stream, the det unit and the result consumer.
// The loader takes the slave side.
interface matriz_loader5x5_if #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 25
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       flush;
  logic [N_ELEM*DATA_W-1:0]   matrix;
  logic                       det_start;
  logic                       det_done;
  logic [DATA_W-1:0]          det_in;
  logic                       res_valid;
  logic                       res_ready;
  logic [DATA_W-1:0]          res_det;
  logic                       res_err;

  modport master (
    output in_valid, in_data, flush,
    output det_done, det_in, res_ready,
    input  in_ready, matrix, det_start,
    input  res_valid, res_det, res_err
  );

  modport slave (
    input  in_valid, in_data, flush,
    input  det_done, det_in, res_ready,
    output in_ready, matrix, det_start,
    output res_valid, res_det, res_err
  );
endinterface

// File: rtl/matriz_loader5x5.sv
// Loads a 5x5 byte matrix from a stream, drives the det unit handshake
// and returns its determinant (or a watchdog abort) on a result port.
module matriz_loader5x5 #(
  parameter int DATA_W    = 8,
  parameter int N_ELEM    = 25,
  parameter int TIMEOUT   = 4096,
  parameter int START_LOW = 2
) (
  input logic clk,
  input logic rst,
  matriz_loader5x5_if.slave bus
);

  localparam int IW   = $clog2(N_ELEM);
  localparam int WW   = $clog2(TIMEOUT);
  localparam int RW   = $clog2(START_LOW) + 1;
  localparam int MW   = N_ELEM * DATA_W;

  localparam logic [IW-1:0] LAST   = IW'(N_ELEM - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RC_MAX = RW'(START_LOW - 1);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    RESULT,
    RECOVER
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]     idx_q;
  logic [MW-1:0]     matrix_q;
  logic              start_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdet_q;
  logic              rerr_q;
  logic [WW-1:0]     wdog_q;
  logic [RW-1:0]     rcnt_q;

  logic xfer;
  logic last;
  logic done_ok;
  logic tmo;
  logic acc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    last    = 1'b0;
    done_ok = 1'b0;
    tmo     = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      FILL: begin
        // flush beats a simultaneous element; that element is dropped
        xfer = bus.in_valid && !bus.flush;
        last = xfer && (idx_q == LAST);
        if (last) state_d = RUN;
      end
      RUN: begin
        done_ok = bus.det_done;
        tmo     = !bus.det_done && (wdog_q == WD_MAX);
        if (done_ok || tmo) state_d = RESULT;
      end
      RESULT: begin
        acc = bus.res_ready;
        if (acc) state_d = RECOVER;
      end
      RECOVER: begin
        if (rcnt_q == RC_MAX) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      matrix_q <= '0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdet_q   <= '0;
      rerr_q   <= 1'b0;
      wdog_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      if (state_q == FILL && bus.flush) idx_q <= '0;
      for (int i = 0; i < N_ELEM; i++) begin
        if (xfer && idx_q == IW'(i))
          matrix_q[i*DATA_W +: DATA_W] <= bus.in_data;
      end
      if (xfer) idx_q <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        start_q <= 1'b1;
        wdog_q  <= '0;
      end
      if (state_q == RUN) wdog_q <= wdog_q + 1'b1;
      if (done_ok) begin
        rdet_q   <= bus.det_in;
        rerr_q   <= 1'b0;
        rvalid_q <= 1'b1;
      end
      if (tmo) begin
        rdet_q   <= '0;
        rerr_q   <= 1'b1;
        rvalid_q <= 1'b1;
      end
      if (acc) begin
        rvalid_q <= 1'b0;
        start_q  <= 1'b0;
        rcnt_q   <= '0;
      end
      if (state_q == RECOVER) rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.matrix    = matrix_q;
  assign bus.det_start = start_q;
  assign bus.res_valid = rvalid_q;
  assign bus.res_det   = rdet_q;
  assign bus.res_err   = rerr_q;

endmodule

// File: tb/tb_matriz_loader5x5.sv
// Directed bench for matriz_loader5x5 with a small det-unit stub that
// computes the 5x5 determinant mod 256 from the matrix bus.
module tb_matriz_loader5x5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matriz_loader5x5_if #(.DATA_W(8), .N_ELEM(25)) bus ();

  matriz_loader5x5 #(
    .DATA_W(8), .N_ELEM(25), .TIMEOUT(16), .START_LOW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int nchk = 0;
  int nerr = 0;
  bit stub_en = 1'b1;
  int scnt = 0;

  typedef struct {
    logic [199:0] m;
    bit           rnd;
    int           hold;
    bit           tmo;
    logic [7:0]   exp_det;
    logic         exp_err;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [7:0] det5(input logic [199:0] m);
    logic [7:0] acc;
    logic [7:0] prod;
    int p[5];
    int inv;
    acc = 8'h00;
    for (int a = 0; a < 5; a++)
    for (int b = 0; b < 5; b++)
    for (int c = 0; c < 5; c++)
    for (int d = 0; d < 5; d++)
    for (int e = 0; e < 5; e++) begin
      if (((1<<a)|(1<<b)|(1<<c)|(1<<d)|(1<<e)) == 31) begin
        p[0] = a; p[1] = b; p[2] = c; p[3] = d; p[4] = e;
        inv = 0;
        for (int i = 0; i < 5; i++)
          for (int j = i + 1; j < 5; j++)
            if (p[i] > p[j]) inv++;
        prod = 8'h01;
        for (int r = 0; r < 5; r++)
          prod = prod * m[(r*5 + p[r])*8 +: 8];
        if (inv % 2 == 1) acc = acc - prod;
        else              acc = acc + prod;
      end
    end
    return acc;
  endfunction

  function automatic logic [199:0] diag(input logic [7:0] d0, d1, d2, d3, d4);
    logic [199:0] m;
    m = '0;
    m[0*8 +: 8]  = d0;
    m[6*8 +: 8]  = d1;
    m[12*8 +: 8] = d2;
    m[18*8 +: 8] = d3;
    m[24*8 +: 8] = d4;
    return m;
  endfunction

  // det unit stub: done a few cycles after start, held until start drops
  always @(posedge clk) begin
    if (rst || !stub_en || !bus.det_start) begin
      bus.det_done <= 1'b0;
      bus.det_in   <= 8'h00;
      scnt         <= 0;
    end else if (scnt == 3) begin
      bus.det_done <= 1'b1;
      bus.det_in   <= det5(bus.matrix);
    end else begin
      scnt <= scnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [199:0] act,
                     input logic [199:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic stream(input logic [199:0] m, input bit rnd,
                        output int cyc);
    int i;
    int guard;
    i = 0;
    guard = 0;
    cyc = 0;
    while (i < 25 && guard < 2000) begin
      @(negedge clk);
      guard++;
      cyc++;
      if (rnd && $urandom_range(1, 0) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = m[i*8 +: 8];
        if (bus.in_ready) i++;
      end
    end
    if (guard >= 2000) chk("stream_bound", 200'(guard), 200'(0));
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int cyc;
    int k;
    int bad;
    logic [7:0] sdet;
    logic serr;
    stub_en = !v.tmo;
    stream(v.m, v.rnd, cyc);
    chk({nm, ":start_pre"}, 200'(bus.det_start), 200'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, ":start_rise"}, 200'(bus.det_start), 200'(1));
    chk({nm, ":ready_run"}, 200'(bus.in_ready), 200'(0));
    if (!v.rnd) chk({nm, ":xfer_cycles"}, 200'(cyc), 200'(25));
    if (v.tmo) begin
      k = 0;
      while (!bus.res_valid && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      chk({nm, ":tmo_latency"}, 200'(k), 200'(16));
    end else begin
      k = 0;
      while (bus.det_done !== 1'b1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (k >= 100) chk({nm, ":done_bound"}, 200'(k), 200'(0));
      chk({nm, ":rv_pre"}, 200'(bus.res_valid), 200'(0));
      @(posedge clk); #1;
      chk({nm, ":rv_post"}, 200'(bus.res_valid), 200'(1));
    end
    chk({nm, ":res_det"}, 200'(bus.res_det), 200'(v.exp_det));
    chk({nm, ":res_err"}, 200'(bus.res_err), 200'(v.exp_err));
    chk({nm, ":matrix"}, bus.matrix, v.m);
    sdet = bus.res_det;
    serr = bus.res_err;
    bad = 0;
    for (int c = 0; c < v.hold; c++) begin
      @(negedge clk);
      if (bus.res_det !== sdet || bus.res_err !== serr ||
          bus.res_valid !== 1'b1 || bus.det_start !== 1'b1 ||
          bus.in_ready !== 1'b0 || bus.matrix !== v.m) bad++;
    end
    if (v.hold > 0) chk({nm, ":hold_stable"}, 200'(bad), 200'(0));
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({nm, ":rv_drop"}, 200'(bus.res_valid), 200'(0));
    chk({nm, ":start_drop"}, 200'(bus.det_start), 200'(0));
    chk({nm, ":rec_ready0"}, 200'(bus.in_ready), 200'(0));
    @(posedge clk); #1;
    chk({nm, ":rec_ready1"}, 200'(bus.in_ready), 200'(0));
    @(posedge clk); #1;
    chk({nm, ":fill_ready"}, 200'(bus.in_ready), 200'(1));
    chk({nm, ":matrix_kept"}, bus.matrix, v.m);
  endtask

  initial begin
    int cyc;
    logic [199:0] m;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.flush     = 1'b0;
    bus.res_ready = 1'b0;

    tbl[0] = '{diag(8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 1'b0, 0, 1'b0, 8'h01, 1'b0};
    tbl[1] = '{diag(8'h02, 8'h01, 8'h01, 8'h01, 8'h01), 1'b1, 0, 1'b0, 8'h02, 1'b0};
    tbl[2] = '{diag(8'h04, 8'h04, 8'h04, 8'h04, 8'h01), 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{diag(8'h01, 8'h01, 8'h00, 8'h01, 8'h01), 1'b1, 0, 1'b0, 8'h00, 1'b0};
    m = diag(8'h03, 8'h05, 8'h01, 8'h01, 8'h01);
    m[1*8 +: 8]  = 8'h07;
    m[9*8 +: 8]  = 8'h09;
    m[13*8 +: 8] = 8'h80;
    tbl[4] = '{m, 1'b0, 0, 1'b0, 8'h0F, 1'b0};
    m = diag(8'h00, 8'h00, 8'h01, 8'h01, 8'h01);
    m[1*8 +: 8] = 8'h01;
    m[5*8 +: 8] = 8'h01;
    tbl[5] = '{m, 1'b0, 50, 1'b0, 8'hFF, 1'b0};
    tbl[6] = '{diag(8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 1'b0, 0, 1'b1, 8'h00, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 200'(bus.in_ready), 200'(1));
    chk("rst_det_start", 200'(bus.det_start), 200'(0));
    chk("rst_res_valid", 200'(bus.res_valid), 200'(0));
    chk("rst_res_det", 200'(bus.res_det), 200'(0));
    chk("rst_res_err", 200'(bus.res_err), 200'(0));
    chk("rst_matrix", bus.matrix, 200'(0));

    for (int t = 0; t < 7; t++)
      run_vec($sformatf("vec%0d", t), tbl[t]);

    // partial load of 10 junk bytes, then flush with a dropped element
    stub_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
    end
    @(negedge clk);
    bus.in_data = 8'h77;
    bus.flush   = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    run_vec("flush", tbl[1]);

    // reset while the det unit is busy
    stub_en = 1'b0;
    stream(tbl[0].m, 1'b0, cyc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstrun_start", 200'(bus.det_start), 200'(0));
    chk("rstrun_ready", 200'(bus.in_ready), 200'(1));
    chk("rstrun_rvalid", 200'(bus.res_valid), 200'(0));
    chk("rstrun_matrix", bus.matrix, 200'(0));
    @(negedge clk);
    rst = 1'b0;
    run_vec("after_rst", tbl[4]);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
